// File: rtl/ram_line_bridge_pkg.sv
// Shared cache-side definitions for the RAM line bridge: FSM encoding, default widths,
// ram_rnw encoding and the beat-index width helper.
package ram_line_bridge_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned LINE_W_DEF = 64;
    localparam int unsigned MEM_DW_DEF = 16;

    localparam logic RAM_RD = 1'b1;
    localparam logic RAM_WR = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_BEAT   = 3'd1,
        ST_RD_REQ    = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_DROP = 3'd5
    } state_e;

    // Beat index width, never narrower than one bit.
    function automatic int unsigned beat_bits(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ram_line_bridge_beat_ctr.sv
// Beat index for one line transfer, with a registered last-beat flag.
module ram_line_bridge_beat_ctr #(
    parameter int unsigned BEATS = 4,
    parameter int unsigned BW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [BW-1:0] beat_o,
    output logic          last_o
);

    logic [BW-1:0] beat_q;
    logic          last_q;

    // last_q tracks (beat_q == BEATS-1) without a comparator on the output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q <= '0;
            last_q <= (BEATS == 1);
        end else if (clr_i) begin
            beat_q <= '0;
            last_q <= (BEATS == 1);
        end else if (inc_i) begin
            beat_q <= beat_q + BW'(1);
            last_q <= ((32'(beat_q) + 32'd2) == BEATS);
        end
    end

    assign beat_o = beat_q;
    assign last_o = last_q;

endmodule

// File: rtl/ram_line_bridge.sv
// Moves one cache line per ram_aval request over a narrow req/rdy memory bus.
// Optional per-beat stall timeout is enabled with the RAM_TIMEOUT_EN macro.
module ram_line_bridge
    import ram_line_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned MEM_DW = MEM_DW_DEF
`ifdef RAM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ram_aval,
    input  logic                           ram_rnw,
    input  logic [ADDR_W-1:0]              ram_addr,
    input  logic [LINE_W-1:0]              ram_wdata,
    output logic                           ram_ack,
    output logic [LINE_W-1:0]              ram_rdata,
    output logic                           ram_err,
    output logic                           busy,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W+beat_bits(LINE_W/MEM_DW)-1:0] mem_addr,
    output logic [MEM_DW-1:0]              mem_wdata,
    input  logic                           mem_rdy,
    input  logic                           mem_rvalid,
    input  logic [MEM_DW-1:0]              mem_rdata
);

    localparam int unsigned BEATS = LINE_W / MEM_DW;
    localparam int unsigned BW    = beat_bits(BEATS);
    localparam int unsigned MA_W  = ADDR_W + BW;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   rdata_q;
    logic                ack_q;
    logic                busy_q;
    logic                req_q;
    logic                we_q;
    logic [MA_W-1:0]     maddr_q;
    logic [MEM_DW-1:0]   wdata_q;

    logic [BW-1:0]       beat;
    logic [BW-1:0]       beat_nxt;
    logic                last;
    logic                beat_clr_c;
    logic                beat_inc_c;
    logic [LINE_W-1:0]   line_fill_c;

    ram_line_bridge_beat_ctr #(
        .BEATS (BEATS),
        .BW    (BW)
    ) u_beat_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (beat_clr_c),
        .inc_i  (beat_inc_c),
        .beat_o (beat),
        .last_o (last)
    );

    assign beat_nxt = beat + BW'(1);

    always_comb begin
        beat_clr_c = (state_q == ST_IDLE) && ram_aval;
        beat_inc_c = !last && (((state_q == ST_WR_BEAT) && mem_rdy) ||
                               ((state_q == ST_RD_WAIT) && mem_rvalid));
    end

    // Line buffer with the returning read beat merged into its slice.
    always_comb begin
        line_fill_c = line_q;
        line_fill_c[32'(beat) * MEM_DW +: MEM_DW] = mem_rdata;
    end

`ifdef RAM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          active_c;
    logic          progress_c;

    always_comb begin
        active_c   = (state_q == ST_WR_BEAT) || (state_q == ST_RD_REQ) ||
                     (state_q == ST_RD_WAIT);
        progress_c = ((state_q == ST_WR_BEAT) && mem_rdy) ||
                     ((state_q == ST_RD_REQ)  && mem_rdy) ||
                     ((state_q == ST_RD_WAIT) && mem_rvalid);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
`ifdef RAM_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef RAM_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (ram_aval) begin
                        addr_q  <= ram_addr;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        we_q    <= (ram_rnw == RAM_WR);
                        maddr_q <= {ram_addr, BW'(0)};
                        // Reads start from a zeroed buffer so unread beats return 0.
                        line_q  <= (ram_rnw == RAM_RD) ? '0 : ram_wdata;
                        wdata_q <= (ram_rnw == RAM_RD) ? '0 : ram_wdata[MEM_DW-1:0];
                        state_q <= (ram_rnw == RAM_RD) ? ST_RD_REQ : ST_WR_BEAT;
`ifdef RAM_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                end
                ST_WR_BEAT: begin
                    if (mem_rdy) begin
                        if (last) begin
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            ack_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end else begin
                            maddr_q <= {addr_q, beat_nxt};
                            wdata_q <= line_q[32'(beat_nxt) * MEM_DW +: MEM_DW];
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_rdy) begin
                        req_q   <= 1'b0;
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        line_q <= line_fill_c;
                        if (last) begin
                            rdata_q <= line_fill_c;
                            busy_q  <= 1'b0;
                            ack_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end else begin
                            req_q   <= 1'b1;
                            maddr_q <= {addr_q, beat_nxt};
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                ST_ACK: begin
                    state_q <= ST_WAIT_DROP;
                end
                ST_WAIT_DROP: begin
                    if (!ram_aval) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef RAM_TIMEOUT_EN
            // Per-beat stall limit; abort overrides whatever the case above held.
            if (active_c) begin
                if (progress_c) begin
                    tmo_q <= '0;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_q   <= '0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
                    err_q   <= 1'b1;
                    state_q <= ST_ACK;
                    if (state_q != ST_WR_BEAT) begin
                        rdata_q <= line_q;
                    end
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
`endif
        end
    end

    assign ram_ack   = ack_q;
    assign ram_rdata = rdata_q;
    assign busy      = busy_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
`ifdef RAM_TIMEOUT_EN
    assign ram_err   = err_q;
`else
    assign ram_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_line_bridge.sv
// Self-checking bench for ram_line_bridge: transaction-level memory model, per-cycle
// bus/ack compare, directed line write-back/fill scenarios.
module tb_ram_line_bridge;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 64;
    localparam int unsigned MEM_DW = 16;
    localparam int unsigned BEATS  = LINE_W / MEM_DW;
    localparam int unsigned BW     = 2;
    localparam int unsigned MA_W   = ADDR_W + BW;
    localparam int unsigned TMO    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ram_aval;
    logic              ram_rnw;
    logic [ADDR_W-1:0] ram_addr;
    logic [LINE_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [LINE_W-1:0] ram_rdata;
    logic              ram_err;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [MA_W-1:0]   mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic              mem_rdy;
    logic              mem_rvalid;
    logic [MEM_DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    ram_line_bridge #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .MEM_DW (MEM_DW)
`ifdef RAM_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TMO)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ram_aval   (ram_aval),
        .ram_rnw    (ram_rnw),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_ack    (ram_ack),
        .ram_rdata  (ram_rdata),
        .ram_err    (ram_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdy    (mem_rdy),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [MA_W-1:0]   addr;
        logic              we;
        logic [MEM_DW-1:0] wdata;
    } beat_t;

    typedef struct {
        logic rd;
        logic err;
    } ack_t;

    int n_chk  = 0;
    int n_fail = 0;

    beat_t             exp_beats[$];
    ack_t              exp_acks[$];
    logic [MEM_DW-1:0] mem_m [int];
    logic [LINE_W-1:0] fill_m = '0;
    int                cyc = 0;
    int                start_cyc = 0;
    int                ack_cyc = -1;
    int                req_cnt = 0;
    logic              rd_pend = 1'b0;
    logic [MEM_DW-1:0] rd_pend_data = '0;
    int                rd_pend_beat = 0;
    int                stall_beat = -1;
    int                stall_left = 0;
    logic              stuck = 1'b0;
    logic              ack_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: ready policy and in-order read return one cycle after acceptance.
    initial begin
        mem_rdy    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rd_pend && !reset) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_pend_data;
                fill_m[rd_pend_beat * MEM_DW +: MEM_DW] = rd_pend_data;
                rd_pend = 1'b0;
            end
            if (stuck) begin
                mem_rdy = 1'b0;
            end else if (mem_req && stall_left > 0 && int'(mem_addr[BW-1:0]) == stall_beat) begin
                mem_rdy = 1'b0;
                stall_left--;
            end else begin
                mem_rdy = 1'b1;
            end
        end
    end

    // Per-cycle compare against the expected beat stream and completion queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req) begin
                req_cnt++;
                if (exp_beats.size() == 0) begin
                    check("spurious_mem_req", mem_req, 0);
                end else begin
                    check("mem_addr", mem_addr, exp_beats[0].addr);
                    check("mem_we", mem_we, exp_beats[0].we);
                    if (exp_beats[0].we) check("mem_wdata", mem_wdata, exp_beats[0].wdata);
                    if (mem_rdy) begin
                        if (exp_beats[0].we) begin
                            mem_m[int'(exp_beats[0].addr)] = exp_beats[0].wdata;
                        end else begin
                            rd_pend      = 1'b1;
                            rd_pend_data = mem_m[int'(exp_beats[0].addr)];
                            rd_pend_beat = int'(exp_beats[0].addr[BW-1:0]);
                        end
                        void'(exp_beats.pop_front());
                    end
                end
            end
            if (ram_ack) begin
                ack_cyc = cyc;
                check("ack_one_cycle", ack_prev, 0);
                check("busy_at_ack", busy, 0);
                if (exp_acks.size() == 0) begin
                    check("spurious_ram_ack", ram_ack, 0);
                end else begin
                    check("ram_err", ram_err, exp_acks[0].err);
                    if (exp_acks[0].rd) check("ram_rdata", ram_rdata, fill_m);
                    if (exp_acks[0].err) exp_beats.delete();
                    else check("beats_left_at_ack", exp_beats.size(), 0);
                    void'(exp_acks.pop_front());
                end
            end else begin
                check("busy", busy, (exp_acks.size() > 0) && (cyc > start_cyc));
            end
            ack_prev = ram_ack;
        end
    end

    task automatic start_txn(input logic rnw, input logic [ADDR_W-1:0] a,
                             input logic [LINE_W-1:0] wd, input logic err);
        @(negedge clk);
        start_cyc = cyc;
        req_cnt   = 0;
        ack_cyc   = -1;
        if (rnw) fill_m = '0;
        for (int i = 0; i < int'(BEATS); i++) begin
            exp_beats.push_back('{addr: {a, BW'(i)}, we: !rnw, wdata: wd[i * MEM_DW +: MEM_DW]});
        end
        exp_acks.push_back('{rd: rnw, err: err});
        ram_aval  = 1'b1;
        ram_rnw   = rnw;
        ram_addr  = a;
        ram_wdata = wd;
    endtask

    task automatic wait_ack(input string name, input int budget);
        int n = 0;
        while (ack_cyc < 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ack_seen"}, ack_cyc >= 0, 1);
    endtask

    task automatic end_txn();
        @(negedge clk);
        ram_aval = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ram_ack"}, ram_ack, 0);
        check({name, "_ram_rdata"}, ram_rdata, 0);
        check({name, "_ram_err"}, ram_err, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_mem_req"}, mem_req, 0);
        check({name, "_mem_we"}, mem_we, 0);
        check({name, "_mem_addr"}, mem_addr, 0);
        check({name, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line);
        for (int i = 0; i < int'(BEATS); i++) begin
            mem_m[int'({a, BW'(i)})] = line[i * MEM_DW +: MEM_DW];
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int n;
        reset     = 1'b1;
        ram_aval  = 1'b0;
        ram_rnw   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: write-back, zero-wait memory; ack in cycle BEATS+2 counting the request cycle as 1.
        start_txn(1'b0, 16'h0012, 64'h4444_3333_2222_1111, 1'b0);
        wait_ack("t1", 20);
        check("t1_latency", ack_cyc - start_cyc + 1, 6);
        check("t1_mem_48", mem_m[32'h48], 16'h1111);
        check("t1_mem_49", mem_m[32'h49], 16'h2222);
        check("t1_mem_4a", mem_m[32'h4A], 16'h3333);
        check("t1_mem_4b", mem_m[32'h4B], 16'h4444);
        end_txn();

        // 2: fill, rvalid one cycle after rdy.
        preload(16'h0003, 64'hDDDD_CCCC_BBBB_AAAA);
        start_txn(1'b1, 16'h0003, 64'h0, 1'b0);
        wait_ack("t2", 30);
        check("t2_latency", ack_cyc - start_cyc + 1, 10);
        check("t2_rdata_lit", ram_rdata, 64'hDDDD_CCCC_BBBB_AAAA);
        end_txn();
        check("t2_rdata_held", ram_rdata, 64'hDDDD_CCCC_BBBB_AAAA);

        // 3: five stall cycles on beat 2 of a write.
        stall_beat = 2;
        stall_left = 5;
        start_txn(1'b0, 16'h0100, 64'h0D0C_0B0A_0908_0706, 1'b0);
        wait_ack("t3", 40);
        check("t3_latency", ack_cyc - start_cyc + 1, 11);
        check("t3_stall_used", stall_left, 0);
        check("t3_mem_402", mem_m[32'h402], 16'h0B0A);
        stall_beat = -1;
        end_txn();

        // 4: ram_aval held after ack must not restart; re-rise starts a new line.
        preload(16'h0007, 64'h1234_5678_9ABC_DEF0);
        start_txn(1'b1, 16'h0007, 64'h0, 1'b0);
        wait_ack("t4", 30);
        repeat (4) begin
            @(negedge clk);
            check("t4_hold_mem_req", mem_req, 0);
            check("t4_hold_busy", busy, 0);
        end
        end_txn();
        check("t4_rdata_lit", ram_rdata, 64'h1234_5678_9ABC_DEF0);
        start_txn(1'b0, 16'h0007, 64'hFEED_F00D_CAFE_BEEF, 1'b0);
        wait_ack("t4b", 20);
        check("t4b_latency", ack_cyc - start_cyc + 1, 6);
        check("t4b_mem_1f", mem_m[32'h1F], 16'hFEED);
        end_txn();

        // 5: asynchronous reset in RD_WAIT of beat 1, then a clean fill.
        preload(16'h0008, 64'h4040_3030_2020_1010);
        start_txn(1'b1, 16'h0008, 64'h0, 1'b0);
        n = 0;
        while (!(mem_req && mem_rdy && mem_addr[BW-1:0] == 2'd1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_beat1", n < 30, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t5_async");
        exp_beats.delete();
        exp_acks.delete();
        rd_pend  = 1'b0;
        ack_prev = 1'b0;
        ram_aval = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        start_txn(1'b1, 16'h0008, 64'h0, 1'b0);
        wait_ack("t5", 30);
        check("t5_latency", ack_cyc - start_cyc + 1, 10);
        check("t5_rdata_lit", ram_rdata, 64'h4040_3030_2020_1010);
        end_txn();

`ifdef RAM_TIMEOUT_EN
        // 6: stuck memory aborts after TMO request cycles, next line runs normally.
        stuck = 1'b1;
        start_txn(1'b0, 16'h0055, 64'h1111_2222_3333_4444, 1'b1);
        wait_ack("t6", 40);
        check("t6_req_cycles", req_cnt, TMO);
        check("t6_latency", ack_cyc - start_cyc + 1, TMO + 2);
        stuck = 1'b0;
        end_txn();
        preload(16'h0055, 64'h0606_0505_0404_0303);
        start_txn(1'b1, 16'h0055, 64'h0, 1'b0);
        wait_ack("t6b", 30);
        check("t6b_latency", ack_cyc - start_cyc + 1, 10);
        check("t6b_rdata_lit", ram_rdata, 64'h0606_0505_0404_0303);
        end_txn();
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
